// File: rtl/toi2s_pkg.sv
// Shared defaults and FSM state type for the I2S receiver.
//   DATA_W_DEF  : default captured sample width per channel
//   TIMEOUT_DEF : default clk cycles between bck rising edges before lock is lost
//   state_e     : receiver framing state
package toi2s_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned TIMEOUT_DEF = 1023;

   typedef enum logic [1:0] {
      ST_WAIT     = 2'd0,
      ST_RX_LEFT  = 2'd1,
      ST_RX_RIGHT = 2'd2
   } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bck/ws/d0 on clk, deframes left/right slots and
// presents the last complete stereo pair, MSB-aligned.
//   clk, reset       : system clock, asynchronous active-high reset
//   ena              : receive enable; low forces WAIT
//   i2s_bck/ws/d0    : asynchronous I2S bit clock, word select, data
//   left_data        : last complete left sample
//   right_data       : last complete right sample
//   sample_valid     : one-clk pulse when the pair has been updated
//   locked           : high while frames are being received
module i2s_rx
   import toi2s_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ena,
   input  logic              i2s_bck,
   input  logic              i2s_ws,
   input  logic              i2s_d0,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              sample_valid,
   output logic              locked
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic              bck_s, ws_s, d_s;
   logic              bck_d_q;
   logic              bck_rise_c;
   logic              bit_stb_q, bit_ws_q, bit_d_q;
   logic              prev_ws_q;
   logic              ws_change_c;
   logic              timeout_c;
   logic [TMR_W-1:0]  tmr_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] stage_q;
   logic [DATA_W-1:0] word_c;
   logic              commit_left_c, commit_right_c;
   state_e            state_q, state_next;

   sync_2ff u_sync_bck (.clk(clk), .reset(reset), .d(i2s_bck), .q(bck_s));
   sync_2ff u_sync_ws  (.clk(clk), .reset(reset), .d(i2s_ws),  .q(ws_s));
   sync_2ff u_sync_d0  (.clk(clk), .reset(reset), .d(i2s_d0),  .q(d_s));

   // Edge detect, word-select change and timeout (bck edge wins over timeout)
   always_comb begin
      bck_rise_c  = bck_s & ~bck_d_q;
      ws_change_c = bit_stb_q & (bit_ws_q ^ prev_ws_q);
      timeout_c   = (tmr_q == TMR_W'(TIMEOUT)) & ~bck_rise_c;
   end

   // Current slot word with the strobed bit merged in; bits past DATA_W are dropped
   always_comb begin
      word_c = shift_q;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (bit_cnt_q == CNT_W'(DATA_W - 1 - i)) word_c[i] = bit_d_q;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_WAIT;
      else       state_q <= state_next;
   end

   // Next state and commit strobes
   always_comb begin
      state_next     = state_q;
      commit_left_c  = 1'b0;
      commit_right_c = 1'b0;
      if (!ena || timeout_c) begin
         state_next = ST_WAIT;
      end else if (ws_change_c) begin
         case (state_q)
            ST_WAIT: begin
               if (!bit_ws_q) state_next = ST_RX_LEFT;
            end
            ST_RX_LEFT: begin
               if (bit_ws_q) begin
                  commit_left_c = 1'b1;
                  state_next    = ST_RX_RIGHT;
               end
            end
            ST_RX_RIGHT: begin
               if (!bit_ws_q) begin
                  commit_right_c = 1'b1;
                  state_next     = ST_RX_LEFT;
               end
            end
            default: state_next = ST_WAIT;
         endcase
      end
   end

   // Bit pipeline, slot shifter, timeout counter and output registers.
   // The strobed bit is registered once after the edge so a commit lands
   // sample_valid three clk after the pin edge is first captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bck_d_q      <= 1'b0;
         bit_stb_q    <= 1'b0;
         bit_ws_q     <= 1'b0;
         bit_d_q      <= 1'b0;
         prev_ws_q    <= 1'b0;
         tmr_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         stage_q      <= '0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
      end else begin
         bck_d_q   <= bck_s;
         bit_stb_q <= bck_rise_c;
         if (bck_rise_c) begin
            bit_ws_q <= ws_s;
            bit_d_q  <= d_s;
         end
         // ws history is kept even when disabled so a restart sees only real changes
         if (bit_stb_q) prev_ws_q <= bit_ws_q;

         if (!ena || bck_rise_c || timeout_c) tmr_q <= '0;
         else                                 tmr_q <= tmr_q + TMR_W'(1);

         if (!ena || ws_change_c) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
         end else if (bit_stb_q) begin
            shift_q <= word_c;
            if (bit_cnt_q != CNT_W'(DATA_W)) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end

         if (commit_left_c) stage_q <= word_c;

         sample_valid <= commit_right_c;
         if (commit_right_c) begin
            left_data  <= stage_q;
            right_data <= word_c;
         end

         if (state_next == ST_WAIT) locked <= 1'b0;
         else if (commit_right_c)   locked <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: frames of varying slot width are driven with
// clk = 16x bck; expected pairs are computed from the frame values and pushed
// when the committing bck edge is issued; a monitor pops and compares.
module tb_i2s_rx;

   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 1023;
   localparam int HALF    = 8;

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
      logic [31:0] cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset, ena, i2s_bck, i2s_ws, i2s_d0;
   logic [DATA_W-1:0] left_data, right_data;
   logic              sample_valid, locked;

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   exp_t        exp_q[$];
   string       pt_name[$];
   logic [31:0] pt_act[$];
   logic [31:0] pt_req[$];

   logic [15:0] hold_l = '0, hold_r = '0;
   int          widths[6] = '{8, 12, 16, 20, 24, 32};

   i2s_rx #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .ena(ena),
      .i2s_bck(i2s_bck), .i2s_ws(i2s_ws), .i2s_d0(i2s_d0),
      .left_data(left_data), .right_data(right_data),
      .sample_valid(sample_valid), .locked(locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: a slot of n bits keeps its first DATA_W bits, MSB-aligned
   function automatic logic [15:0] align(input logic [31:0] v, input int n);
      logic [63:0] x;
      x = {32'd0, v};
      if (n >= DATA_W) x = x >> (n - DATA_W);
      else             x = x << (DATA_W - n);
      return x[15:0];
   endfunction

   function automatic logic [31:0] mask(input int n);
      logic [32:0] m;
      m = (33'd1 << n) - 33'd1;
      return m[31:0];
   endfunction

   task automatic post(input string nm, input logic [31:0] act, input logic [31:0] req);
      pt_name.push_back(nm);
      pt_act.push_back(act);
      pt_req.push_back(req);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One I2S bit: data/ws change while bck low, sampled at the bck rise
   task automatic send_bit(input logic ws, input logic d, input bit do_rst,
                           input bit commit, input exp_t e);
      i2s_bck = 1'b0;
      i2s_ws  = ws;
      i2s_d0  = d;
      if (do_rst) begin
         reset = 1'b1;
         repeat (2) step();
         post("rst_mid_left",   32'(left_data),    0);
         post("rst_mid_right",  32'(right_data),   0);
         post("rst_mid_locked", 32'(locked),       0);
         post("rst_mid_valid",  32'(sample_valid), 0);
         hold_l = '0;
         hold_r = '0;
         repeat (2) step();
         reset = 1'b0;
         repeat (HALF - 4) step();
      end else begin
         repeat (HALF) step();
      end
      i2s_bck = 1'b1;
      if (commit) begin
         e.cyc = 32'(cyc + 4);
         exp_q.push_back(e);
      end
      repeat (HALF) step();
   endtask

   // dk: 0 none, 1 reset pulse at bit db, 2 ena low for bits db..db+2
   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                             input bit emit, input int dk, input int db);
      exp_t e;
      e.l   = align(l, n);
      e.r   = align(r, n);
      e.cyc = '0;
      for (int i = 0; i < 2 * n; i++) begin
         logic ws_b, d_b;
         if (i < n) d_b = l[n - 1 - i];
         else       d_b = r[2 * n - 1 - i];
         ws_b = (i >= n - 1) && (i < 2 * n - 1);
         if (dk == 2 && i == db)     ena = 1'b0;
         if (dk == 2 && i == db + 2) post("ena_low_locked", 32'(locked), 0);
         if (dk == 2 && i == db + 3) ena = 1'b1;
         send_bit(ws_b, d_b, (dk == 1) && (i == db), emit && (i == 2 * n - 1), e);
      end
      if (emit) begin
         hold_l = e.l;
         hold_r = e.r;
      end
   endtask

   task automatic send_random(input bit emit, input int dk, input int db);
      int w;
      w = widths[$urandom_range(0, 5)];
      send_frame($urandom & mask(w), $urandom & mask(w), w, emit, dk, db);
   endtask

   // Monitor: resolves posted point checks and scoreboards every sample_valid
   string       m_nm;
   logic [31:0] m_a, m_r;
   exp_t        m_e;
   always @(negedge clk) begin
      while (pt_name.size() > 0) begin
         m_nm = pt_name.pop_front();
         m_a  = pt_act.pop_front();
         m_r  = pt_req.pop_front();
         n_chk++;
         if (m_a !== m_r) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", m_nm, m_a, m_r);
         end
      end
      if (sample_valid) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: sample_valid=1 at cycle %0d, required none", cyc);
         end else begin
            m_e = exp_q.pop_front();
            if (left_data !== m_e.l) begin
               n_fail++;
               $display("FAIL left_data: got 0x%0h, required 0x%0h", left_data, m_e.l);
            end
            n_chk++;
            if (right_data !== m_e.r) begin
               n_fail++;
               $display("FAIL right_data: got 0x%0h, required 0x%0h", right_data, m_e.r);
            end
            n_chk++;
            if (32'(cyc) != m_e.cyc) begin
               n_fail++;
               $display("FAIL latency: valid at cycle %0d, required %0d", cyc, m_e.cyc);
            end
            n_chk++;
            if (locked !== 1'b1) begin
               n_fail++;
               $display("FAIL locked_on_valid: got %b, required 1", locked);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      ena     = 1'b1;
      i2s_bck = 1'b0;
      i2s_ws  = 1'b0;
      i2s_d0  = 1'b0;

      // Reset held with bck toggling
      for (int i = 0; i < 10; i++) begin
         step();
         if (i % 2 == 1) i2s_bck = ~i2s_bck;
         i2s_ws = 1'($urandom);
         i2s_d0 = 1'($urandom);
         post("rst_valid", 32'(sample_valid), 0);
      end
      post("rst_left",   32'(left_data),  0);
      post("rst_right",  32'(right_data), 0);
      post("rst_locked", 32'(locked),     0);
      i2s_bck = 1'b0;
      i2s_ws  = 1'b0;
      i2s_d0  = 1'b0;
      step();
      reset = 1'b0;
      repeat (4) step();

      // Fixed 16/32/8-bit frames then random widths, one continuous stream
      send_frame(32'hA5C3, 32'h1234, 16, 1'b0, 0, 0);
      send_frame(32'hA5C3, 32'h1234, 16, 1'b1, 0, 0);
      send_frame(32'hA5C3, 32'h1234, 16, 1'b1, 0, 0);
      send_frame(32'hDEADBEEF, 32'h0000FFFF, 32, 1'b1, 0, 0);
      send_frame(32'h5A, 32'hFF, 8, 1'b1, 0, 0);
      for (int i = 0; i < 6; i++) send_random(1'b1, 0, 0);
      repeat (8) step();
      post("locked_streaming", 32'(locked), 1);

      // bck stops past the timeout: lock drops, outputs hold
      i2s_bck = 1'b0;
      repeat (TIMEOUT + 20) step();
      post("timeout_locked", 32'(locked),     0);
      post("timeout_left",   32'(left_data),  32'(hold_l));
      post("timeout_right",  32'(right_data), 32'(hold_r));

      // Restart: first frame discarded, reset mid-right-slot, ena drop mid-left-slot
      send_random(1'b0, 0, 0);
      send_random(1'b1, 0, 0);
      send_frame($urandom & mask(16), $urandom & mask(16), 16, 1'b0, 1, 16 + 5);
      send_random(1'b1, 0, 0);
      send_random(1'b1, 0, 0);
      send_frame($urandom & mask(16), $urandom & mask(16), 16, 1'b0, 2, 4);
      send_random(1'b1, 0, 0);
      for (int i = 0; i < 4; i++) send_random(1'b1, 0, 0);

      repeat (50) step();
      post("scoreboard_drained", 32'(exp_q.size()), 0);
      post("final_left",  32'(left_data),  32'(hold_l));
      post("final_right", 32'(right_data), 32'(hold_r));
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Cycle budget for the whole run
   initial begin
      repeat (60000) @(posedge clk);
      post("watchdog_expired", 1, 0);
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "cycle budget exhausted");
   end

endmodule
